switch_event_decoder: RTL and testbench

- Sits directly downstream of the 10-bit switch synchronizer.
- Debounces the synchronized, active-low switch levels and turns each debounced press into a single Sudoku input event: digit 1–9 or erase.
- Events are held on a valid/ready handshake for the game-control logic.
- Also exports the debounced switch levels.

---
 rtl/switch_event_decoder.sv | 132 +++++++++++++
 tb/tb_switch_event_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_event_decoder.sv
// switch_event_decoder
//   Debounces ten synchronized, active-low switch levels and turns each
//   debounced press into a single Sudoku input event (digit 1-9 or erase),
//   held on a valid/ready handshake for the game-control logic.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active high
//   sw_n[9:0]    synchronized switch levels, active low (8:0 digits 1-9, 9 erase)
//   sw_level     debounced switch levels, active high
//   evt_valid    an event is held
//   evt_code     1-9 for a digit, 0 for erase
//   evt_ready    consumer accepts the held event
//   evt_dropped  one-cycle pulse: a press was lost because the slot was full
//   collision    one-cycle pulse: more than one press edge in the same cycle
//
// State | meaning
// IDLE  | no event held
// HOLD  | an event is held, waiting for a transfer
module switch_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sw_n,
  output logic [9:0] sw_level,
  output logic       evt_valid,
  output logic [3:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_dropped,
  output logic       collision
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt [10];
  logic [9:0]       raw;
  logic [9:0]       press;
  logic [3:0]       sel_code;
  logic             any_press;
  logic             multi_press;
  logic [3:0]       code_d;
  logic             dropped_d;

  assign raw = ~sw_n;

  // Debounce: a level is accepted once it has differed from the debounced
  // level on DEBOUNCE_CYCLES consecutive edges; any agreeing sample restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_level <= '0;
      for (int i = 0; i < 10; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (raw[i] == sw_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TC) begin
          sw_level[i] <= raw[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press edges are taken from the debounce terminal count rather than from
  // sw_level itself, so the event is captured on the same edge the level rises.
  always_comb begin
    press = '0;
    for (int i = 0; i < 10; i++) begin
      press[i] = raw[i] & ~sw_level[i] & (cnt[i] == TC);
    end
  end

  assign any_press   = |press;
  assign multi_press = |(press & (press - 10'd1));

  // Erase wins, then the lowest digit; the descending loop leaves the lowest.
  always_comb begin
    sel_code = 4'd0;
    if (!press[9]) begin
      for (int i = 8; i >= 0; i--) begin
        if (press[i]) sel_code = 4'(i + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = evt_code;
    dropped_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_press) begin
          state_d = HOLD;
          code_d  = sel_code;
        end
      end
      HOLD: begin
        if (evt_ready) begin
          if (any_press) code_d = sel_code;
          else           state_d = IDLE;
        end else if (any_press) begin
          dropped_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      evt_code    <= 4'd0;
      evt_dropped <= 1'b0;
      collision   <= 1'b0;
    end else begin
      state_q     <= state_d;
      evt_code    <= code_d;
      evt_dropped <= dropped_d;
      collision   <= multi_press;
    end
  end

  assign evt_valid = (state_q == HOLD);

endmodule

// File: tb/tb_switch_event_decoder.sv
// Bench for switch_event_decoder with DEBOUNCE_CYCLES = 4. Directed scenarios
// followed by random switch activity, all checked against a run-length
// reference model of the debouncer plus a one-slot event holder.
module tb_switch_event_decoder;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sw_n;
  logic [9:0] sw_level;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic       evt_ready;
  logic       evt_dropped;
  logic       collision;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [9:0] m_level;
  logic       m_runval [10];
  int         m_run    [10];
  logic       m_valid;
  logic [3:0] m_code;
  logic       m_drop;
  logic       m_coll;

  // scenario observation counters
  int valid_cycles, drop_cnt, coll_cnt;
  logic [3:0] seen_code;

  switch_event_decoder #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_n        (sw_n),
    .sw_level    (sw_level),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ready   (evt_ready),
    .evt_dropped (evt_dropped),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    for (int i = 0; i < 10; i++) begin
      m_runval[i] = 1'b0;
      m_run[i]    = 0;
    end
    m_valid = 1'b0;
    m_code  = 4'd0;
    m_drop  = 1'b0;
    m_coll  = 1'b0;
  endtask

  // A level is accepted when the last N raw samples all disagree with it.
  task automatic model_clock();
    logic [9:0] raw, new_level, pr;
    int         npress;
    logic [3:0] sel;
    raw = ~sw_n;
    new_level = m_level;
    for (int i = 0; i < 10; i++) begin
      if (m_run[i] > 0 && raw[i] == m_runval[i]) begin
        if (m_run[i] < 1000) m_run[i]++;
      end else begin
        m_runval[i] = raw[i];
        m_run[i]    = 1;
      end
      if (m_run[i] >= N && m_runval[i] != m_level[i]) new_level[i] = m_runval[i];
    end
    pr = new_level & ~m_level;
    m_level = new_level;
    npress = $countones(pr);
    sel = 4'd0;
    if (!pr[9]) begin
      for (int i = 0; i < 9; i++) begin
        if (pr[i]) begin
          sel = 4'(i + 1);
          break;
        end
      end
    end
    m_coll = (npress > 1);
    m_drop = 1'b0;
    if (!m_valid) begin
      if (npress > 0) begin
        m_valid = 1'b1;
        m_code  = sel;
      end
    end else if (evt_ready) begin
      if (npress > 0) m_code = sel;
      else            m_valid = 1'b0;
    end else if (npress > 0) begin
      m_drop = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_clock();
    @(negedge clk);
    chk("model", {sw_level, evt_valid, evt_code, evt_dropped, collision},
                 {m_level, m_valid, m_code, m_drop, m_coll});
    if (evt_valid) begin
      valid_cycles++;
      seen_code = evt_code;
    end
    if (evt_dropped) drop_cnt++;
    if (collision)   coll_cnt++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_obs();
    valid_cycles = 0;
    drop_cnt     = 0;
    coll_cnt     = 0;
    seen_code    = 4'hF;
  endtask

  initial begin
    rst       = 1'b1;
    sw_n      = '1;
    evt_ready = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    steps(2);

    // asynchronous reset mid-cycle with switches pressed and an event held
    sw_n = 10'h3FF & ~10'h028;
    steps(N);
    chk("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_rst", {sw_level, evt_valid, evt_code, evt_dropped, collision}, 32'd0);
    sw_n = '1;
    sw_n[3] = 1'b0;
    steps(2);
    rst = 1'b0;
    steps(N - 1);
    chk("rst_hold_level_early", {31'd0, sw_level[3]}, 32'd0);
    step();
    chk("rst_hold_level", {31'd0, sw_level[3]}, 32'd1);
    chk("rst_hold_code", {evt_valid, evt_code}, {1'b1, 4'd4});

    sw_n = '1;
    evt_ready = 1'b1;
    steps(6);

    // single press on bit 8
    clear_obs();
    sw_n[8] = 1'b0;
    steps(10);
    chk("single_valid_cycles", valid_cycles, 1);
    chk("single_code", {28'd0, seen_code}, 32'd9);
    clear_obs();
    sw_n[8] = 1'b1;
    steps(N - 1);
    chk("release_early", {31'd0, sw_level[8]}, 32'd1);
    step();
    chk("release_level", {31'd0, sw_level[8]}, 32'd0);
    steps(3);
    chk("release_no_event", valid_cycles, 0);

    // bounce rejection on bit 0
    clear_obs();
    sw_n[0] = 1'b0; steps(3);
    sw_n[0] = 1'b1; steps(1);
    sw_n[0] = 1'b0; steps(3);
    chk("bounce_level", {31'd0, sw_level[0]}, 32'd0);
    chk("bounce_no_event", valid_cycles, 0);
    steps(4);
    chk("bounce_event", valid_cycles, 1);
    chk("bounce_code", {28'd0, seen_code}, 32'd1);
    sw_n = '1;
    steps(6);

    // hold and drop
    evt_ready = 1'b0;
    clear_obs();
    sw_n[1] = 1'b0; steps(N);
    chk("hold_code", {evt_valid, evt_code}, {1'b1, 4'd2});
    sw_n[6] = 1'b0; steps(N + 2);
    chk("hold_code_kept", {28'd0, evt_code}, 32'd2);
    chk("drop_count", drop_cnt, 1);
    evt_ready = 1'b1;
    step();
    chk("drop_transfer_idle", {31'd0, evt_valid}, 32'd0);
    sw_n = '1;
    steps(6);

    // collision and priority
    clear_obs();
    sw_n[2] = 1'b0; sw_n[5] = 1'b0; sw_n[9] = 1'b0;
    steps(N);
    chk("coll_erase", {evt_valid, evt_code, collision}, {1'b1, 4'd0, 1'b1});
    steps(3);
    chk("coll_once", coll_cnt, 1);
    sw_n = '1; steps(6);
    clear_obs();
    sw_n[2] = 1'b0; sw_n[5] = 1'b0;
    steps(N);
    chk("coll_digit", {evt_valid, evt_code, collision}, {1'b1, 4'd3, 1'b1});
    sw_n = '1; steps(6);

    // back-to-back
    evt_ready = 1'b0;
    clear_obs();
    sw_n[4] = 1'b0; steps(N);
    chk("b2b_first", {evt_valid, evt_code}, {1'b1, 4'd5});
    sw_n[7] = 1'b0; steps(N - 1);
    evt_ready = 1'b1;
    step();
    chk("b2b_second", {evt_valid, evt_code, evt_dropped}, {1'b1, 4'd8, 1'b0});
    step();
    chk("b2b_idle", {31'd0, evt_valid}, 32'd0);
    chk("b2b_no_drop", drop_cnt, 0);
    sw_n = '1; steps(6);

    // random activity: slowly toggling switches, random ready, rare resets
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 10; b++) begin
        if ($urandom_range(0, 5) == 0) sw_n[b] = ~sw_n[b];
      end
      evt_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
